// File: rtl/instr_register_pkg.sv
// Shared types for instr_register and its front-end controller.
// Opcodes, operand/address widths, controller states and the captured request record.
package instr_register_pkg;

  localparam int DEPTH = 32;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t a;
    operand_t b;
  } req_t;

  // Division-by-zero requests are consumed but never reach the register.
  function automatic logic is_div0(req_t r);
    return ((r.opc == DIV) || (r.opc == MOD)) && (r.b == '0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves past the winner whenever the grant is taken.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;
  int            idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      cand = IW'(idx);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/instr_reg_ctrl.sv
// Front-end for instr_register: arbitrates requesters onto the single write port,
// keeps the circular queue pointers/count and hands entries to one consumer.
module instr_reg_ctrl
  import instr_register_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = instr_register_pkg::DEPTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  opcode_t            req_opcode    [NUM_REQ],
  input  operand_t           req_operand_a [NUM_REQ],
  input  operand_t           req_operand_b [NUM_REQ],
  input  logic               flush,
  input  logic               rd_ready,
  output logic               iw_valid,
  output logic               load_en,
  output opcode_t            opcode,
  output operand_t           operand_a,
  output operand_t           operand_b,
  output address_t           write_pointer,
  output address_t           read_pointer,
  output logic [5:0]         count,
  output logic               full,
  output logic               empty,
  output logic               err_div0,
  output ctrl_state_t        state
);

  localparam int IW = $clog2(NUM_REQ);

  // Handshake rule for both sides: a transfer happens on a rising edge where
  // valid and ready are both high; ready never looks at the payload.

  ctrl_state_t        state_q, state_d;
  address_t           wr_ptr, rd_ptr;
  logic [5:0]         cnt;
  logic [NUM_REQ-1:0] arb_req, grant;
  logic [IW-1:0]      grant_idx;
  logic               can_grant, hs, rd_hs, div0;
  req_t               sel;

  // A load already in flight reserves its slot, so full can never overflow.
  assign can_grant = reset_n && (state_q != FLUSH) && !flush &&
                     (({1'b0, cnt} + 7'(load_en)) < 7'(DEPTH));
  assign arb_req   = req_valid & {NUM_REQ{can_grant}};

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (arb_req),
    .advance   (hs),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign hs        = |grant;
  assign sel       = '{opc: req_opcode[grant_idx],
                       a:   req_operand_a[grant_idx],
                       b:   req_operand_b[grant_idx]};
  assign div0      = is_div0(sel);

  assign iw_valid = reset_n && (cnt != '0) && (state_q != FLUSH);
  assign rd_hs    = iw_valid && rd_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = ACTIVE;
      ACTIVE:  if ((cnt == '0) && !load_en && !hs) state_d = IDLE;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = FLUSH;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      load_en   <= 1'b0;
      err_div0  <= 1'b0;
      opcode    <= ZERO;
      operand_a <= '0;
      operand_b <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
    end else begin
      state_q  <= state_d;
      load_en  <= hs && !div0;
      err_div0 <= hs && div0;
      if (hs && !div0) begin
        opcode    <= sel.opc;
        operand_a <= sel.a;
        operand_b <= sel.b;
      end
      if (load_en) wr_ptr <= wr_ptr + address_t'(1);
      if (state_q == FLUSH) begin
        rd_ptr <= wr_ptr;
        cnt    <= '0;
      end else begin
        if (rd_hs) rd_ptr <= rd_ptr + address_t'(1);
        case ({load_en, rd_hs})
          2'b10:   cnt <= cnt + 6'd1;
          2'b01:   cnt <= cnt - 6'd1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  assign write_pointer = wr_ptr;
  assign read_pointer  = rd_ptr;
  assign count         = cnt;
  assign full          = (cnt == 6'(DEPTH));
  assign empty         = (cnt == '0);
  assign state         = state_q;

endmodule
